// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - async-SRAM bus responder with read latency, byte lanes and access counters
module sram_responder #(
    parameter int ADDR_BITS  = 3,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        chip_enable_sram,
    input  logic        wr_enable_sram,
    input  logic        rd_enable_sram,
    input  logic        ub,
    input  logic        lb,
    input  logic [17:0] addr,
    inout  wire  [15:0] sram,
    output logic [7:0]  wr_count,
    output logic [7:0]  rd_count,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // The input-stage capture is the first equal-address clock, so READ_WAIT
    // needs RD_LATENCY-1 further clocks; it always spans at least one clock.
    localparam logic [2:0] WAIT_LAST = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_WAIT  = 2'd2,
        READ_DRIVE = 2'd3
    } state_t;

    state_t state, state_next;

    logic                 s_ce, s_we, s_oe, s_ub, s_lb;
    logic [17:0]          s_addr;
    logic [15:0]          s_data;

    logic [17:0]          rd_addr;
    logic [2:0]           wait_cnt;

    logic [ADDR_BITS-1:0] wr_idx;
    logic [15:0]          wr_data;
    logic                 wr_ub, wr_lb;

    logic [15:0]          mem [DEPTH];

    logic                 drive_hi, drive_lo;
    logic [15:0]          dout;

    logic                 addr_same;
    logic                 upper_nz;
    logic                 commit;
    logic                 wr_commit;
    logic                 rd_entry;

    assign addr_same = (s_addr == rd_addr);
    assign upper_nz  = |s_addr[17:ADDR_BITS];
    assign commit    = (state == WRITE) && (state_next != WRITE);
    assign wr_commit = commit && !(wr_ub && wr_lb);
    assign rd_entry  = (state != READ_DRIVE) && (state_next == READ_DRIVE);

    // Input stage: every decision below works from these registered copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ce   <= 1'b1;
            s_we   <= 1'b1;
            s_oe   <= 1'b1;
            s_ub   <= 1'b1;
            s_lb   <= 1'b1;
            s_addr <= '0;
            s_data <= '0;
        end else begin
            s_ce   <= chip_enable_sram;
            s_we   <= wr_enable_sram;
            s_oe   <= rd_enable_sram;
            s_ub   <= ub;
            s_lb   <= lb;
            s_addr <= addr;
            s_data <= sram;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: write wins over read; reads wait for a stable address.
    always_comb begin
        state_next = IDLE;
        if (!s_ce && !s_we) begin
            state_next = WRITE;
        end else if (!s_ce && !s_oe) begin
            case (state)
                IDLE, WRITE: state_next = READ_WAIT;
                READ_WAIT:   state_next = (addr_same && wait_cnt >= WAIT_LAST) ? READ_DRIVE : READ_WAIT;
                READ_DRIVE:  state_next = addr_same ? READ_DRIVE : READ_WAIT;
                default:     state_next = IDLE;
            endcase
        end
    end

    // Read address tracking: a new address (or a fresh entry) restarts the wait count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr  <= '0;
            wait_cnt <= '0;
        end else if (state_next == READ_WAIT) begin
            if (state != READ_WAIT || !addr_same) begin
                rd_addr  <= s_addr;
                wait_cnt <= 3'd1;
            end else if (wait_cnt != 3'd7) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
        end
    end

    // Hold the most recent WRITE-cycle address, data and lanes until the write commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            wr_data <= '0;
            wr_ub   <= 1'b1;
            wr_lb   <= 1'b1;
        end else if (state_next == WRITE) begin
            wr_idx  <= s_addr[ADDR_BITS-1:0];
            wr_data <= s_data;
            wr_ub   <= s_ub;
            wr_lb   <= s_lb;
        end
    end

    // Memory array is not reset; lanes update only on the cycle WRITE exits.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (!wr_lb) mem[wr_idx][7:0]  <= wr_data[7:0];
            if (!wr_ub) mem[wr_idx][15:8] <= wr_data[15:8];
        end
    end

    // Saturating counters and sticky out-of-range address flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
            addr_err <= 1'b0;
        end else begin
            if (wr_commit && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
            if (rd_entry && rd_count != 8'hFF)  rd_count <= rd_count + 8'd1;
            if ((state_next == WRITE || state_next == READ_WAIT) && upper_nz) addr_err <= 1'b1;
        end
    end

    // Registered lane enables so the bus turns on with the READ_DRIVE state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_hi <= 1'b0;
            drive_lo <= 1'b0;
            dout     <= '0;
        end else begin
            drive_hi <= (state_next == READ_DRIVE) && !s_ub;
            drive_lo <= (state_next == READ_DRIVE) && !s_lb;
            dout     <= mem[s_addr[ADDR_BITS-1:0]];
        end
    end

    assign sram[15:8] = drive_hi ? dout[15:8] : 8'hzz;
    assign sram[7:0]  = drive_lo ? dout[7:0]  : 8'hzz;

endmodule
